ir_prefetch_queue: RTL

Parametrised instruction register with a small prefetch queue in front of it, the successor to the single 10-bit IR. It buffers up to DEPTH instruction words fetched from memory. On request it loads the oldest word into the architectural IR and exposes the decoded opcode and register fields to the control FSM. A flush input discards prefetched words on taken branches or writes to the PC register (R7).

---
 rtl/ir_prefetch_queue.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ir_prefetch_queue.sv
// Instruction register fed by a DEPTH-entry prefetch queue; all state updates on
// the falling clock edge, and the decoded fields are combinational slices of IR.
module ir_prefetch_queue #(
    parameter int IW    = 10,
    parameter int DEPTH = 4,
    parameter int OPW   = 4,
    parameter int RW    = 3
) (
    input  logic                   Clock,
    input  logic                   Resetn,
    input  logic [IW-1:0]          DIN,
    input  logic                   Wr,
    input  logic                   IRin,
    input  logic                   Flush,
    output logic [IW-1:0]          IR,
    output logic                   IRvalid,
    output logic [OPW-1:0]         Opcode,
    output logic [RW-1:0]          RX,
    output logic [RW-1:0]          RY,
    output logic                   Empty,
    output logic                   Full,
    output logic [$clog2(DEPTH):0] Count,
    output logic                   Overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_INC   = AW'(1);
    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);

    generate
        if ((OPW + 2*RW != IW) || (DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_params
            $error("ir_prefetch_queue: illegal parameter combination");
        end
    endgenerate

    logic [IW-1:0] mem_q [DEPTH];
    logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [AW:0]   count_q, count_d;
    logic [IW-1:0] ir_q, ir_d;
    logic          irvalid_q, irvalid_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          overflow_q, overflow_d;
    logic          pop_s, push_s;

    // A push is still accepted at Full when the same edge frees a slot by popping.
    always_comb begin
        pop_s  = IRin && !empty_q;
        push_s = Wr && (!full_q || pop_s);
    end

    // Next-state logic; Flush overrides every other request on the edge.
    always_comb begin
        rptr_d     = rptr_q;
        wptr_d     = wptr_q;
        count_d    = count_q;
        ir_d       = ir_q;
        irvalid_d  = irvalid_q;
        empty_d    = empty_q;
        full_d     = full_q;
        overflow_d = overflow_q;
        if (Flush) begin
            rptr_d     = '0;
            wptr_d     = '0;
            count_d    = '0;
            ir_d       = '0;
            irvalid_d  = 1'b0;
            empty_d    = 1'b1;
            full_d     = 1'b0;
            overflow_d = 1'b0;
        end else begin
            if (pop_s) begin
                ir_d      = mem_q[rptr_q];
                irvalid_d = 1'b1;
                rptr_d    = rptr_q + PTR_INC;
            end else if (IRin) begin
                irvalid_d = 1'b0;
            end else begin
                irvalid_d = irvalid_q;
            end
            if (push_s) begin
                wptr_d = wptr_q + PTR_INC;
            end else begin
                wptr_d = wptr_q;
            end
            if (Wr && !push_s) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end
            count_d = count_q + (AW+1)'(push_s) - (AW+1)'(pop_s);
            empty_d = (count_d == '0);
            full_d  = (count_d == DEPTH_CNT);
        end
    end

    // Control and IR registers, cleared asynchronously by Resetn.
    always_ff @(negedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            rptr_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            ir_q       <= '0;
            irvalid_q  <= 1'b0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            ir_q       <= ir_d;
            irvalid_q  <= irvalid_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array carries no reset; entries are only read after being written.
    always_ff @(negedge Clock) begin
        if (push_s && !Flush) begin
            mem_q[wptr_q] <= DIN;
        end
    end

    assign IR       = ir_q;
    assign IRvalid  = irvalid_q;
    assign Opcode   = ir_q[IW-1 -: OPW];
    assign RX       = ir_q[2*RW-1 -: RW];
    assign RY       = ir_q[RW-1:0];
    assign Empty    = empty_q;
    assign Full     = full_q;
    assign Count    = count_q;
    assign Overflow = overflow_q;

endmodule
